// File: rtl/ps2_kbd_fifo.sv
// PS/2 keyboard deframer with a first-word-fall-through scan-code FIFO.
// Raw pins are synchronized into the system clock; frames are checked for odd parity and stop bit.
module ps2_kbd_fifo #(
  parameter int FIFO_DEPTH     = 8,
  parameter int TIMEOUT_CYCLES = 5000
) (
  input  logic                         clock,
  input  logic                         reset,
  input  logic                         ps2_clk,
  input  logic                         ps2_data,
  input  logic                         rd_en,
  input  logic                         clr_flags,
  output logic [7:0]                   scan_code,
  output logic                         valid,
  output logic [$clog2(FIFO_DEPTH):0]  count,
  output logic                         overflow,
  output logic                         frame_err
);
  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int TW = $clog2(TIMEOUT_CYCLES);
  localparam logic [TW-1:0] TMAX = TW'(TIMEOUT_CYCLES - 1);

  typedef enum logic {IDLE, RECV} state_t;

  logic          r_clk_m, r_clk_q1, r_clk_q2;
  logic          r_data_m, r_data_q1;
  state_t        r_state, w_state_nxt;
  logic [3:0]    r_bitcnt;
  logic [8:0]    r_shift;
  logic [TW-1:0] r_timer;
  logic [7:0]    r_mem [FIFO_DEPTH];
  logic [AW-1:0] r_wp, r_rp;
  logic [AW:0]   r_count;
  logic          r_ovf, r_ferr;
  logic          w_fall, w_good, w_push, w_bad, w_full, w_pop, w_wr;

  // Bus idles high, so the synchronizers preset to 1 to avoid a false fall after reset.
  always_ff @(posedge clock) begin
    if (reset) begin
      r_clk_m   <= 1'b1;
      r_clk_q1  <= 1'b1;
      r_clk_q2  <= 1'b1;
      r_data_m  <= 1'b1;
      r_data_q1 <= 1'b1;
    end else begin
      r_clk_m   <= ps2_clk;
      r_clk_q1  <= r_clk_m;
      r_clk_q2  <= r_clk_q1;
      r_data_m  <= ps2_data;
      r_data_q1 <= r_data_m;
    end
  end

  assign w_fall = r_clk_q2 & ~r_clk_q1;
  assign w_good = (^r_shift[7:0] ^ r_shift[8]) & r_data_q1;

  always_ff @(posedge clock) begin
    if (reset) r_state <= IDLE;
    else       r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    w_push      = 1'b0;
    w_bad       = 1'b0;
    case (r_state)
      IDLE: if (w_fall && !r_data_q1) w_state_nxt = RECV;
      RECV: begin
        if (w_fall) begin
          if (r_bitcnt == 4'd9) begin
            w_state_nxt = IDLE;
            w_push      = w_good;
            w_bad       = ~w_good;
          end
        end else if (r_timer == TMAX) begin
          w_state_nxt = IDLE;
        end
      end
      default: w_state_nxt = IDLE;
    endcase
  end

  // Shift register collects 8 data bits plus parity; the stop bit is judged live.
  always_ff @(posedge clock) begin
    if (reset) begin
      r_bitcnt <= '0;
      r_timer  <= '0;
      r_shift  <= '0;
    end else if (r_state == IDLE) begin
      r_bitcnt <= '0;
      r_timer  <= '0;
    end else if (w_fall) begin
      r_timer <= '0;
      if (r_bitcnt != 4'd9) begin
        r_shift  <= {r_data_q1, r_shift[8:1]};
        r_bitcnt <= r_bitcnt + 4'd1;
      end
    end else begin
      r_timer <= r_timer + 1'b1;
    end
  end

  assign w_full = (r_count == (AW+1)'(FIFO_DEPTH));
  assign w_pop  = rd_en & (r_count != '0);
  assign w_wr   = w_push & (~w_full | w_pop);

  always_ff @(posedge clock) begin
    if (w_wr) r_mem[r_wp] <= r_shift[7:0];
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      r_wp    <= '0;
      r_rp    <= '0;
      r_count <= '0;
      r_ovf   <= 1'b0;
      r_ferr  <= 1'b0;
    end else begin
      if (w_wr)  r_wp <= r_wp + 1'b1;
      if (w_pop) r_rp <= r_rp + 1'b1;
      case ({w_wr, w_pop})
        2'b10:   r_count <= r_count + 1'b1;
        2'b01:   r_count <= r_count - 1'b1;
        default: r_count <= r_count;
      endcase
      if (w_push && w_full && !w_pop) r_ovf <= 1'b1;
      else if (clr_flags)             r_ovf <= 1'b0;
      if (w_bad)          r_ferr <= 1'b1;
      else if (clr_flags) r_ferr <= 1'b0;
    end
  end

  assign valid     = (r_count != '0);
  assign scan_code = valid ? r_mem[r_rp] : 8'h00;
  assign count     = r_count;
  assign overflow  = r_ovf;
  assign frame_err = r_ferr;
endmodule

// File: tb/tb_ps2_kbd_fifo.sv
// Bench for ps2_kbd_fifo: bit-bangs PS/2 frames and scoreboards the queued scan codes.
module tb_ps2_kbd_fifo;
  logic       clock = 1'b0;
  logic       reset, ps2_clk, ps2_data, rd_en, clr_flags;
  logic [7:0] scan_code;
  logic       valid, overflow, frame_err;
  logic [3:0] count;

  ps2_kbd_fifo #(.FIFO_DEPTH(8), .TIMEOUT_CYCLES(5000)) dut (
    .clock(clock), .reset(reset), .ps2_clk(ps2_clk), .ps2_data(ps2_data),
    .rd_en(rd_en), .clr_flags(clr_flags), .scan_code(scan_code), .valid(valid),
    .count(count), .overflow(overflow), .frame_err(frame_err)
  );

  always #10 clock = ~clock;

  int          n_chk  = 0;
  int          n_pass = 0;
  logic [7:0]  expq[$];
  logic        exp_ovf  = 1'b0;
  logic        exp_ferr = 1'b0;

  task automatic chk(input string tag, input int obs, input int exp);
    n_chk++;
    if (obs == exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
  endtask

  task automatic tick(input int n);
    repeat (n) @(negedge clock);
  endtask

  // mode 1: check exact push latency on the stop fall; mode 2: pop in the push cycle
  task automatic send_bit(input logic d, input int mode, input logic [7:0] b);
    ps2_data = d;
    tick(5);
    ps2_clk = 1'b0;
    tick(2);
    if (mode == 1) chk("lat_before", int'(valid), 0);
    if (mode == 2) begin
      chk("pop_on_push_head", int'(scan_code), int'(expq[0]));
      void'(expq.pop_front());
      rd_en = 1'b1;
    end
    tick(1);
    rd_en = 1'b0;
    if (mode == 1) begin
      chk("lat_valid", int'(valid), 1);
      chk("lat_code", int'(scan_code), int'(b));
    end
    tick(5);
    ps2_clk = 1'b1;
    tick(2);
  endtask

  task automatic send_frame(input logic [7:0] b, input logic bad, input int mode);
    logic p;
    p = ~(^b) ^ bad;
    send_bit(1'b0, 0, b);
    for (int i = 0; i < 8; i++) send_bit(b[i], 0, b);
    send_bit(p, 0, b);
    send_bit(1'b1, mode, b);
    if (bad) exp_ferr = 1'b1;
    else if (expq.size() < 8) expq.push_back(b);
    else exp_ovf = 1'b1;
  endtask

  task automatic pop_chk(input string tag);
    chk({tag, "_valid"}, int'(valid), 1);
    if (expq.size() > 0) chk(tag, int'(scan_code), int'(expq.pop_front()));
    rd_en = 1'b1;
    tick(1);
    rd_en = 1'b0;
  endtask

  task automatic chk_state(input string tag);
    chk({tag, "_count"}, int'(count), expq.size());
    chk({tag, "_valid"}, int'(valid), int'(expq.size() != 0));
    chk({tag, "_ovf"},   int'(overflow), int'(exp_ovf));
    chk({tag, "_ferr"},  int'(frame_err), int'(exp_ferr));
  endtask

  task automatic do_clr();
    clr_flags = 1'b1;
    tick(1);
    clr_flags = 1'b0;
    exp_ovf  = 1'b0;
    exp_ferr = 1'b0;
  endtask

  initial begin
    reset = 1'b1; ps2_clk = 1'b1; ps2_data = 1'b1; rd_en = 1'b0; clr_flags = 1'b0;
    tick(3);
    reset = 1'b0;
    tick(2);
    chk("rst_code", int'(scan_code), 0);
    chk_state("rst");

    rd_en = 1'b1;
    tick(1);
    rd_en = 1'b0;
    chk_state("rd_empty");

    // single make code with exact latency
    send_frame(8'h1C, 1'b0, 1);
    chk_state("t1");
    pop_chk("t1_pop");
    chk_state("t1_after");

    // break sequence
    send_frame(8'hF0, 1'b0, 0);
    send_frame(8'h1C, 1'b0, 0);
    chk_state("t2");
    pop_chk("t2_pop0");
    pop_chk("t2_pop1");
    chk_state("t2_after");

    // parity error
    send_frame(8'h1C, 1'b1, 0);
    chk_state("t3");
    do_clr();
    chk_state("t3_clr");

    // overflow, then full push+pop in one cycle
    for (int i = 1; i <= 9; i++) send_frame(8'(i), 1'b0, 0);
    chk_state("t4_full");
    for (int i = 0; i < 8; i++) pop_chk("t4_pop");
    do_clr();
    chk_state("t4_drained");
    for (int i = 1; i <= 8; i++) send_frame(8'(i), 1'b0, 0);
    send_frame(8'h09, 1'b0, 2);
    chk_state("t4b_full");
    for (int i = 0; i < 8; i++) pop_chk("t4b_pop");
    chk_state("t4b_drained");

    // partial frame abandoned by timeout
    send_bit(1'b0, 0, 8'h00);
    for (int i = 0; i < 4; i++) send_bit(1'b1, 0, 8'h00);
    tick(5100);
    send_frame(8'h5A, 1'b0, 0);
    chk_state("t5");
    pop_chk("t5_pop");

    // reset mid-frame with data queued
    send_frame(8'h11, 1'b0, 0);
    send_frame(8'h22, 1'b0, 0);
    send_frame(8'h33, 1'b1, 0);
    send_frame(8'h33, 1'b0, 0);
    chk_state("t6_pre");
    send_bit(1'b0, 0, 8'h00);
    send_bit(1'b1, 0, 8'h00);
    send_bit(1'b0, 0, 8'h00);
    reset = 1'b1;
    tick(2);
    reset = 1'b0;
    expq.delete();
    exp_ovf = 1'b0;
    exp_ferr = 1'b0;
    ps2_data = 1'b1;
    tick(3);
    chk_state("t6_rst");
    send_frame(8'h76, 1'b0, 0);
    chk_state("t6_post");
    pop_chk("t6_pop");
    chk_state("t6_end");

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
